// File: rtl/gba_bus_pkg.sv
// Shared types and defaults for the GBA memory-bus arbiter: arbitration states,
// default channel count and watchdog length, and the bus transfer-size encodings.
package gba_bus_pkg;

  localparam int NUM_DMA_DEF = 4;
  localparam int TIMEOUT_DEF = 1024;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    TO_DMA  = 2'd1,
    DMA_OWN = 2'd2,
    TO_CPU  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/gba_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req, plus whether any bit is set.
module gba_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/gba_bus_arbiter.sv
// CPU/DMA shared-bus arbiter: hands the bus to the highest-priority DMA channel at a
// CPU instruction boundary, re-arbitrates on unit-transfer boundaries, and revokes hung owners.
module gba_bus_arbiter
  import gba_bus_pkg::*;
#(
  parameter int NUM_DMA = NUM_DMA_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  input  logic [1:0]               cpu_size,
  input  logic                     cpu_write,
  input  logic                     cpu_preemptable,
  output logic                     cpu_pause,
  input  logic [NUM_DMA-1:0]       dma_req,
  input  logic [NUM_DMA-1:0][31:0] dma_addr,
  input  logic [NUM_DMA-1:0][31:0] dma_wdata,
  input  logic [NUM_DMA-1:0][1:0]  dma_size,
  input  logic [NUM_DMA-1:0]       dma_write,
  input  logic [NUM_DMA-1:0]       dma_xfer_done,
  output logic [NUM_DMA-1:0]       dma_gnt,
  output logic [31:0]              bus_addr,
  output logic [31:0]              bus_wdata,
  output logic [1:0]               bus_size,
  output logic                     bus_write,
  input  logic                     bus_pause,
  output logic                     dma_active,
  output logic                     timeout_err
);

  localparam int OW = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  arb_state_t         state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [NUM_DMA-1:0] gnt_q, gnt_d;
  logic [NUM_DMA-1:0] mask_q, mask_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [NUM_DMA-1:0] req_eff;
  logic [OW-1:0]      win_idx;
  logic               win_vld;
  logic               boundary;
  logic               expire;

  // A timed-out channel stays masked until it drops its request.
  assign req_eff = dma_req & ~mask_q;

  gba_prio_enc #(.N(NUM_DMA), .IW(OW)) u_prio (
    .req   (req_eff),
    .idx   (win_idx),
    .valid (win_vld)
  );

  assign boundary = !bus_pause && (dma_xfer_done[owner_q] || !dma_req[owner_q]);
  assign expire   = (cnt_q == CW'(TIMEOUT - 1));

  // The lowest pending index is also the correct choice when the owner is still
  // requesting: any lower index outranks it, otherwise the owner itself wins.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = '0;
    err_d   = err_q;
    mask_d  = mask_q & dma_req;
    case (state_q)
      CPU_OWN: begin
        if (win_vld && cpu_preemptable && !bus_pause) begin
          state_d = TO_DMA;
          owner_d = win_idx;
        end
      end
      TO_DMA: begin
        if (!bus_pause) state_d = DMA_OWN;
      end
      DMA_OWN: begin
        cnt_d = cnt_q + 1'b1;
        if (boundary) begin
          cnt_d = '0;
          if (win_vld) owner_d = win_idx;
          else         state_d = TO_CPU;
        end else if (expire) begin
          cnt_d           = '0;
          state_d         = TO_CPU;
          err_d           = 1'b1;
          mask_d[owner_q] = 1'b1;
        end
      end
      TO_CPU: begin
        if (!bus_pause) state_d = CPU_OWN;
      end
      default: state_d = CPU_OWN;
    endcase
    gnt_d = (state_d == DMA_OWN) ? (NUM_DMA'(1) << owner_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= CPU_OWN;
      owner_q <= '0;
      gnt_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Handoff cycles keep the CPU address on the bus but never write.
  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_size  = cpu_size;
    bus_write = cpu_write;
    cpu_pause = 1'b1;
    case (state_q)
      CPU_OWN: cpu_pause = bus_pause;
      DMA_OWN: begin
        bus_addr  = dma_addr[owner_q];
        bus_wdata = dma_wdata[owner_q];
        bus_size  = dma_size[owner_q];
        bus_write = dma_write[owner_q];
      end
      default: bus_write = 1'b0;
    endcase
  end

  assign dma_active  = (state_q != CPU_OWN);
  assign dma_gnt     = gnt_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_gba_bus_arbiter.sv
// Self-checking bench for gba_bus_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a phase-level behavioural model of the arbitration rules.
module tb_gba_bus_arbiter;
  import gba_bus_pkg::*;

  localparam int N  = 4;
  localparam int TO = 1024;
  localparam int PH_CPU = 0, PH_IN = 1, PH_DMA = 2, PH_OUT = 3;

  logic                clk = 1'b0;
  logic                rst_b = 1'b0;
  logic [31:0]         cpu_addr = '0, cpu_wdata = '0;
  logic [1:0]          cpu_size = '0;
  logic                cpu_write = 1'b0, cpu_preemptable = 1'b0;
  logic                cpu_pause;
  logic [N-1:0]        dma_req = '0;
  logic [N-1:0][31:0]  dma_addr = '0, dma_wdata = '0;
  logic [N-1:0][1:0]   dma_size = '0;
  logic [N-1:0]        dma_write = '0, dma_xfer_done = '0;
  logic [N-1:0]        dma_gnt;
  logic [31:0]         bus_addr, bus_wdata;
  logic [1:0]          bus_size;
  logic                bus_write, bus_pause = 1'b0, dma_active, timeout_err;

  int checks = 0, failures = 0;

  int           m_phase, m_owner, m_hold;
  logic [N-1:0] m_mask;
  logic         m_err;

  always #5 clk = ~clk;

  gba_bus_arbiter #(.NUM_DMA(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_b(rst_b),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_write(cpu_write),
    .cpu_preemptable(cpu_preemptable), .cpu_pause(cpu_pause),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_size(dma_size),
    .dma_write(dma_write), .dma_xfer_done(dma_xfer_done), .dma_gnt(dma_gnt),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_size(bus_size), .bus_write(bus_write),
    .bus_pause(bus_pause), .dma_active(dma_active), .timeout_err(timeout_err)
  );

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [1:0] pick_size();
    case ($urandom_range(0, 2))
      0:       return SIZE_BYTE;
      1:       return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = PH_CPU; m_owner = 0; m_hold = 0; m_mask = '0; m_err = 1'b0;
  endtask

  // Arbitration rules stated directly: higher pending wins, else owner keeps, else lowest pending.
  task automatic model_step();
    logic [N-1:0] eff, hi, nmask;
    eff   = dma_req & ~m_mask;
    nmask = m_mask & dma_req;
    case (m_phase)
      PH_CPU: if (eff != 0 && cpu_preemptable && !bus_pause) begin
        m_phase = PH_IN; m_owner = lowest(eff);
      end
      PH_IN:  if (!bus_pause) begin m_phase = PH_DMA; m_hold = 0; end
      PH_DMA: begin
        m_hold++;
        if (!bus_pause && (dma_xfer_done[m_owner] || !dma_req[m_owner])) begin
          m_hold = 0;
          hi = eff & ((N'(1) << m_owner) - N'(1));
          if (hi != 0)            m_owner = lowest(hi);
          else if (eff[m_owner])  m_owner = m_owner;
          else if (eff != 0)      m_owner = lowest(eff);
          else                    m_phase = PH_OUT;
        end else if (m_hold >= TO) begin
          m_phase = PH_OUT; m_err = 1'b1; nmask[m_owner] = 1'b1; m_hold = 0;
        end
      end
      default: if (!bus_pause) m_phase = PH_CPU;
    endcase
    m_mask = nmask;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    cpu_addr = 32'h0300_1000; cpu_write = 1'b1; bus_pause = 1'b1;
    dma_req = 4'b1111; cpu_preemptable = 1'b1;
    #2;
    checks++; if (dma_gnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", dma_gnt); end
    checks++; if (dma_active !== 1'b0) begin failures++; $display("FAIL rst_active got=%b exp=0", dma_active); end
    checks++; if (cpu_pause !== 1'b1) begin failures++; $display("FAIL rst_cpu_pause got=%b exp=1", cpu_pause); end
    checks++; if (bus_addr !== cpu_addr || bus_write !== 1'b1) begin failures++; $display("FAIL rst_bus got=%h/%b exp=%h/1", bus_addr, bus_write, cpu_addr); end
    @(posedge clk); #1;
    checks++; if (dma_gnt !== 4'b0000 || dma_active !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rst_hold got=%b/%b/%b exp=0000/0/0", dma_gnt, dma_active, timeout_err); end
    dma_req = '0; bus_pause = 1'b0; cpu_write = 1'b0;
    rst_b = 1'b1;
    model_reset();
  endtask

  task automatic test_grant();
    for (int k = 0; k < N; k++) begin
      dma_addr[k] = 32'hA000_0000 + 32'(k * 16); dma_wdata[k] = 32'h5500_0000 + 32'(k);
      dma_size[k] = SIZE_HALF;
    end
    dma_write = 4'b0100; cpu_addr = 32'h0300_0010; cpu_write = 1'b1; cpu_size = SIZE_WORD;
    cpu_preemptable = 1'b1; dma_req = 4'b0100;
    @(negedge clk);
    checks++; if (dma_active !== 1'b0 || bus_addr !== cpu_addr) begin failures++; $display("FAIL grant_cpu got=%b/%h exp=0/%h", dma_active, bus_addr, cpu_addr); end
    tick(); @(negedge clk);
    checks++; if (dma_active !== 1'b1 || dma_gnt !== 4'b0000 || cpu_pause !== 1'b1) begin failures++; $display("FAIL to_dma_ctl got=%b/%b/%b exp=1/0000/1", dma_active, dma_gnt, cpu_pause); end
    checks++; if (bus_write !== 1'b0 || bus_addr !== cpu_addr) begin failures++; $display("FAIL to_dma_bus got=%b/%h exp=0/%h", bus_write, bus_addr, cpu_addr); end
    tick(); @(negedge clk);
    checks++; if (dma_gnt !== 4'b0100 || dma_active !== 1'b1) begin failures++; $display("FAIL grant_gnt got=%b/%b exp=0100/1", dma_gnt, dma_active); end
    checks++; if (bus_addr !== 32'hA000_0020 || bus_write !== 1'b1 || bus_size !== SIZE_HALF) begin failures++; $display("FAIL grant_bus got=%h/%b/%b exp=a0000020/1/01", bus_addr, bus_write, bus_size); end
    tick();
  endtask

  task automatic test_preempt();
    dma_req = 4'b0101; dma_xfer_done = 4'b0100;
    @(negedge clk);
    checks++; if (dma_gnt !== 4'b0100) begin failures++; $display("FAIL preempt_before got=%b exp=0100", dma_gnt); end
    tick(); dma_xfer_done = '0; @(negedge clk);
    checks++; if (dma_gnt !== 4'b0001 || dma_active !== 1'b1 || bus_addr !== 32'hA000_0000) begin failures++; $display("FAIL preempt_switch got=%b/%b/%h exp=0001/1/a0000000", dma_gnt, dma_active, bus_addr); end
    tick(); @(negedge clk);
    checks++; if (dma_gnt !== 4'b0001) begin failures++; $display("FAIL preempt_hold got=%b exp=0001", dma_gnt); end
    tick();
  endtask

  task automatic test_release();
    dma_req = 4'b0010; cpu_write = 1'b1;
    @(negedge clk); tick(); @(negedge clk);
    checks++; if (dma_gnt !== 4'b0010) begin failures++; $display("FAIL release_owner got=%b exp=0010", dma_gnt); end
    dma_req = '0;
    tick(); @(negedge clk);
    checks++; if (dma_gnt !== 4'b0000 || bus_write !== 1'b0 || cpu_pause !== 1'b1 || dma_active !== 1'b1) begin failures++; $display("FAIL to_cpu got=%b/%b/%b/%b exp=0000/0/1/1", dma_gnt, bus_write, cpu_pause, dma_active); end
    tick(); @(negedge clk);
    bus_pause = 1'b1; #1;
    checks++; if (cpu_pause !== 1'b1 || dma_active !== 1'b0) begin failures++; $display("FAIL cpu_back_p1 got=%b/%b exp=1/0", cpu_pause, dma_active); end
    bus_pause = 1'b0; #1;
    checks++; if (cpu_pause !== 1'b0 || bus_write !== 1'b1) begin failures++; $display("FAIL cpu_back_p0 got=%b/%b exp=0/1", cpu_pause, bus_write); end
    tick();
  endtask

  task automatic test_timeout();
    int owned;
    dma_req = 4'b1000; cpu_preemptable = 1'b1;
    tick(); tick();
    owned = 0;
    for (int c = 0; c < TO + 20; c++) begin
      @(negedge clk);
      if (dma_gnt !== 4'b1000) break;
      owned++;
      tick();
    end
    checks++; if (owned != TO) begin failures++; $display("FAIL timeout_len got=%0d exp=%0d", owned, TO); end
    checks++; if (dma_gnt !== 4'b0000 || dma_active !== 1'b1 || timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_revoke got=%b/%b/%b exp=0000/1/1", dma_gnt, dma_active, timeout_err); end
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (dma_active !== 1'b0) begin failures++; $display("FAIL timeout_mask got=%b exp=0", dma_active); end
      tick();
    end
    dma_req = '0; tick();
    dma_req = 4'b1000; @(negedge clk);
    checks++; if (dma_active !== 1'b0) begin failures++; $display("FAIL unmask_early got=%b exp=0", dma_active); end
    tick(); @(negedge clk);
    checks++; if (dma_active !== 1'b1 || timeout_err !== 1'b1) begin failures++; $display("FAIL unmask_grant got=%b/%b exp=1/1", dma_active, timeout_err); end
    dma_req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_pause();
    dma_req = 4'b0100; tick(); tick();
    bus_pause = 1'b1; dma_req = 4'b0101; dma_xfer_done = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (dma_gnt !== 4'b0100 || cpu_pause !== 1'b1) begin failures++; $display("FAIL pause_freeze got=%b/%b exp=0100/1", dma_gnt, cpu_pause); end
      tick();
    end
    bus_pause = 1'b0; @(negedge clk);
    checks++; if (dma_gnt !== 4'b0100) begin failures++; $display("FAIL pause_clear got=%b exp=0100", dma_gnt); end
    tick(); dma_xfer_done = '0; @(negedge clk);
    checks++; if (dma_gnt !== 4'b0001) begin failures++; $display("FAIL pause_switch got=%b exp=0001", dma_gnt); end
    tick();
    bus_pause = 1'b1; dma_req = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (dma_gnt !== 4'b0001) begin failures++; $display("FAIL drop_in_pause got=%b exp=0001", dma_gnt); end
      tick();
    end
    bus_pause = 1'b0; tick(); @(negedge clk);
    checks++; if (dma_gnt !== 4'b0100) begin failures++; $display("FAIL drop_after_pause got=%b exp=0100", dma_gnt); end
  endtask

  task automatic test_async_reset();
    cpu_addr = 32'h0800_1234; cpu_write = 1'b1;
    #1 rst_b = 1'b0;
    #1;
    checks++; if (dma_gnt !== 4'b0000 || dma_active !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL arst_ctl got=%b/%b/%b exp=0000/0/0", dma_gnt, dma_active, timeout_err); end
    checks++; if (bus_addr !== cpu_addr || bus_write !== 1'b1) begin failures++; $display("FAIL arst_bus got=%h/%b exp=%h/1", bus_addr, bus_write, cpu_addr); end
    model_reset();
    dma_req = '0;
    #1 rst_b = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    logic [31:0]  ea;
    logic         ew;
    for (int cyc = 0; cyc < 800; cyc++) begin
      cpu_addr = $urandom; cpu_wdata = $urandom; cpu_size = pick_size(); cpu_write = 1'($urandom_range(0, 1));
      cpu_preemptable = ($urandom_range(0, 3) != 0);
      bus_pause = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        dma_addr[i] = $urandom; dma_wdata[i] = $urandom; dma_size[i] = pick_size();
        dma_write[i] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) dma_req[i] = ~dma_req[i];
        dma_xfer_done[i] = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      eg = (m_phase == PH_DMA) ? (N'(1) << m_owner) : '0;
      ea = (m_phase == PH_DMA) ? dma_addr[m_owner] : cpu_addr;
      ew = (m_phase == PH_CPU) ? cpu_write : (m_phase == PH_DMA) ? dma_write[m_owner] : 1'b0;
      checks++; if (dma_gnt !== eg) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, dma_gnt, eg); end
      checks++; if (dma_active !== (m_phase != PH_CPU)) begin failures++; $display("FAIL rnd_active cyc=%0d got=%b exp=%b", cyc, dma_active, m_phase != PH_CPU); end
      checks++; if (cpu_pause !== ((m_phase == PH_CPU) ? bus_pause : 1'b1)) begin failures++; $display("FAIL rnd_cpu_pause cyc=%0d got=%b", cyc, cpu_pause); end
      checks++; if (bus_write !== ew) begin failures++; $display("FAIL rnd_write cyc=%0d got=%b exp=%b", cyc, bus_write, ew); end
      checks++; if (timeout_err !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, timeout_err, m_err); end
      if (m_phase != PH_OUT) begin
        checks++; if (bus_addr !== ea) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, bus_addr, ea); end
      end
      if (m_phase == PH_DMA) begin
        checks++; if (bus_wdata !== dma_wdata[m_owner] || bus_size !== dma_size[m_owner]) begin failures++; $display("FAIL rnd_dma_fields cyc=%0d got=%h/%b", cyc, bus_wdata, bus_size); end
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_grant();
    test_preempt();
    test_release();
    test_timeout();
    test_pause();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
